// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings, parameter limits and helpers for the UART TX scheduler
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } sched_state_t;

   localparam int NUM_REQ_MIN      = 2;
   localparam int NUM_REQ_MAX      = 8;
   localparam int BUSY_TIMEOUT_MIN = 2;
   localparam int BUSY_TIMEOUT_MAX = 15;
   localparam int TIMEOUT_W        = $clog2(BUSY_TIMEOUT_MAX + 1);

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with tx_start/tx_busy handshake
module uart_tx #(
   parameter int CLK_FREQ  = 1000,
   parameter int BAUD_RATE = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CPB = (CLK_FREQ / BAUD_RATE < 2) ? 2 : CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(CPB);

   logic [9:0]    shreg;
   logic [3:0]    bit_cnt;
   logic [CW-1:0] clk_cnt;

   // Frame is {stop, data[7:0], start}, shifted out LSB first; idle shifts in ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '1;
         bit_cnt <= '0;
         clk_cnt <= '0;
         tx_busy <= 1'b0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            shreg   <= {1'b1, data_in, 1'b0};
            bit_cnt <= '0;
            clk_cnt <= '0;
            tx_busy <= 1'b1;
         end
      end else if (clk_cnt == CW'(CPB - 1)) begin
         clk_cnt <= '0;
         shreg   <= {1'b1, shreg[9:1]};
         if (bit_cnt == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   assign tx = shreg[0];

endmodule

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rtl/uart_tx_sched_rr_arbiter.sv - combinational round-robin arbiter, search from ptr upward with wrap
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found                = 1'b1;
            grant[cand[IW-1:0]]  = 1'b1;
            idx                  = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - packet-granular round-robin sharing of one UART transmitter
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int BUSY_TIMEOUT = 4,
   localparam int IW          = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [IW-1:0]        grant_id,
   output logic                 pkt_active,
   output logic                 tx_err
);

   sched_state_t         state, state_nx;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 last_q;
   logic [IW-1:0]        ptr;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [IW-1:0]        arb_idx;
   logic                 arb_found;

   logic [7:0]           req_byte [NUM_REQ];
   logic [IW-1:0]        sel;
   logic                 sel_valid;
   logic                 accept;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .found (arb_found)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_byte[i] = req_data[8*i +: 8];
      end
   end

   // A locked packet pins selection to its owner; other requesters stay blocked.
   always_comb begin
      sel       = pkt_active ? grant_id : arb_idx;
      sel_valid = pkt_active ? req_valid[grant_id] : arb_found;
      req_ready = '0;
      if (state == ST_IDLE && !tx_busy) begin
         if (pkt_active) begin
            req_ready[grant_id] = 1'b1;
         end else begin
            req_ready = arb_grant;
         end
      end
      accept = (state == ST_IDLE) && !tx_busy && sel_valid;
   end

   always_comb begin
      state_nx = state;
      tx_start = 1'b0;
      tx_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tx_start = !tx_busy;
            state_nx = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx = ST_WAIT_DONE;
            end else if (wait_cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1)) begin
               tx_err   = 1'b1;
               state_nx = ST_ISSUE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         tx_data    <= '0;
         last_q     <= 1'b0;
         grant_id   <= '0;
         pkt_active <= 1'b0;
         ptr        <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tx_data    <= req_byte[sel];
                  last_q     <= req_last[sel];
                  grant_id   <= sel;
                  pkt_active <= 1'b1;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
            end
            ST_WAIT_BUSY: begin
               if (!tx_busy) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               // Fairness pointer advances only at packet end, never mid-packet.
               if (!tx_busy && last_q) begin
                  pkt_active <= 1'b0;
                  ptr        <= IW'(wrap_inc(int'(grant_id), NUM_REQ));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench: scheduler + real uart_tx + line decoder, NUM_REQ=3
module tb_uart_tx_sched;
   import uart_pkg::*;

   localparam int NR = 3;
   localparam int BT = 4;

   typedef struct {
      int         rq;
      logic [7:0] data;
      logic       last;
   } item_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          sched_busy;
   logic [1:0]    grant_id;
   logic          pkt_active;
   logic          tx_err;
   logic          tx_line;
   logic          uart_busy;
   logic          busy_force = 1'b0;

   logic          v [NR];
   logic [7:0]    d [NR];
   logic          l [NR];

   int            n_checks = 0;
   int            n_errors = 0;
   item_t         items [$];
   item_t         exp_q [$];
   logic [8:0]    line_q [$];
   int            start_dly [NR];
   int            pause_rq = -1;
   int            pause_after = 0;
   int            pause_left = 0;
   int            dec_cnt = 0;
   logic [7:0]    dec_sh = '0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_valid[i]      = v[i];
         req_data[8*i +: 8] = d[i];
         req_last[i]       = l[i];
      end
   end

   assign sched_busy = busy_force ? 1'b0 : uart_busy;

   uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) u_uart (
      .clk     (clk),
      .rst     (rst),
      .tx_start(tx_start),
      .data_in (tx_data),
      .tx      (tx_line),
      .tx_busy (uart_busy)
   );

   uart_tx_sched #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (sched_busy),
      .grant_id  (grant_id),
      .pkt_active(pkt_active),
      .tx_err    (tx_err)
   );

   // Line decoder: 10 clk/bit, samples mid-bit; bit 8 of each entry flags a bad stop bit.
   always @(negedge clk) begin
      if (rst) begin
         dec_cnt = 0;
      end else if (dec_cnt == 0) begin
         if (tx_line == 1'b0) dec_cnt = 1;
      end else begin
         if (dec_cnt >= 15 && dec_cnt <= 85 && (dec_cnt - 15) % 10 == 0)
            dec_sh[(dec_cnt - 15) / 10] = tx_line;
         if (dec_cnt == 95) begin
            line_q.push_back({~tx_line, dec_sh});
            dec_cnt = 0;
         end else begin
            dec_cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_drive();
      for (int i = 0; i < NR; i++) begin
         v[i] = 1'b0;
         d[i] = 8'h00;
         l[i] = 1'b0;
         start_dly[i] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      busy_force = 1'b0;
      pause_rq = -1;
      pause_left = 0;
      clear_drive();
      items.delete();
      tick();
      tick();
      rst = 1'b0;
      line_q.delete();
   endtask

   task automatic add_item(input int rq, input logic [7:0] data, input logic last);
      item_t it;
      it.rq = rq;
      it.data = data;
      it.last = last;
      items.push_back(it);
   endtask

   function automatic int nth_item(input int rq, input int n);
      int cnt = 0;
      foreach (items[j]) begin
         if (items[j].rq == rq) begin
            if (cnt == n) return j;
            cnt++;
         end
      end
      return -1;
   endfunction

   // Reference: whole packets served round-robin, pointer moves past each finished owner.
   function automatic void build_expected();
      int pos [NR];
      int ptr;
      int idx;
      bit found;
      exp_q.delete();
      for (int i = 0; i < NR; i++) pos[i] = 0;
      ptr = 0;
      do begin
         found = 1'b0;
         for (int k = 0; k < NR; k++) begin
            int c;
            c = (ptr + k) % NR;
            if (!found && nth_item(c, pos[c]) >= 0) begin
               found = 1'b1;
               do begin
                  idx = nth_item(c, pos[c]);
                  exp_q.push_back(items[idx]);
                  pos[c]++;
               end while (!items[idx].last && nth_item(c, pos[c]) >= 0);
               ptr = (c + 1) % NR;
            end
         end
      end while (found);
   endfunction

   task automatic wait_line(input string tag, input int n, input int budget);
      int k = 0;
      while (line_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_line_bound"}, 32'(line_q.size() >= n), 32'd1);
   endtask

   task automatic run_traffic(input string pfx, input int budget);
      int sent [NR];
      int acc_n = 0;
      int start_n = 0;
      int cyc = 0;
      int owner = 0;
      int idx;
      bit locked = 1'b0;
      bit prev_start = 1'b0;
      for (int i = 0; i < NR; i++) sent[i] = 0;
      build_expected();
      while (line_q.size() < exp_q.size() && cyc < budget) begin
         tick();
         cyc++;
         for (int i = 0; i < NR; i++) begin
            idx = nth_item(i, sent[i]);
            v[i] = (idx >= 0) && (cyc > start_dly[i]);
            if (idx >= 0) begin
               d[i] = items[idx].data;
               l[i] = items[idx].last;
            end
            if (i == pause_rq && sent[i] == pause_after && pause_left > 0) begin
               v[i] = 1'b0;
               if (!uart_busy) pause_left--;
            end
         end
         @(negedge clk);
         if (tx_start) begin
            check({pfx, "_start_not_double"}, 32'(prev_start), 32'd0);
            check({pfx, "_start_not_busy"}, 32'(sched_busy), 32'd0);
            if (start_n < exp_q.size()) begin
               check({pfx, "_start_grant"}, 32'(grant_id), 32'(exp_q[start_n].rq));
               check({pfx, "_start_data"}, 32'(tx_data), 32'(exp_q[start_n].data));
            end else begin
               check({pfx, "_extra_start"}, 32'(start_n), 32'(exp_q.size() - 1));
            end
            start_n++;
         end
         prev_start = tx_start;
         if (locked)
            check({pfx, "_ready_locked"}, 32'(req_ready & ~(3'b001 << owner)), 32'd0);
         for (int i = 0; i < NR; i++) begin
            if (v[i] && req_ready[i]) begin
               check({pfx, "_grant_order"}, 32'(i),
                     (acc_n < exp_q.size()) ? 32'(exp_q[acc_n].rq) : 32'hFFFF_FFFF);
               acc_n++;
               sent[i]++;
               owner = i;
               locked = !l[i];
            end
         end
      end
      check({pfx, "_no_timeout"}, 32'(cyc < budget), 32'd1);
      check({pfx, "_accept_count"}, 32'(acc_n), 32'(exp_q.size()));
      foreach (exp_q[j]) begin
         if (j < line_q.size())
            check({pfx, "_line_byte"}, 32'(line_q[j]), 32'({1'b0, exp_q[j].data}));
      end
      clear_drive();
   endtask

   initial begin
      logic [7:0] b1, b2, b3;
      bit prev;
      int k;
      clear_drive();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_pkt_active", 32'(pkt_active), 32'd0);
      check("rst_tx_err", 32'(tx_err), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);

      // Single-byte packet: ready same cycle, start next cycle, lock released after busy falls.
      tick();
      v[0] = 1'b1; d[0] = 8'hA5; l[0] = 1'b1;
      @(negedge clk);
      check("t1_ready_same_cycle", 32'(req_ready), 32'b001);
      check("t1_no_start_yet", 32'(tx_start), 32'd0);
      tick();
      v[0] = 1'b0;
      @(negedge clk);
      check("t1_start_next", 32'(tx_start), 32'd1);
      check("t1_tx_data", 32'(tx_data), 32'hA5);
      check("t1_pkt_active", 32'(pkt_active), 32'd1);
      wait_line("t1", 1, 300);
      if (line_q.size() > 0) check("t1_line", 32'(line_q[0]), 32'h0A5);
      k = 0;
      while (uart_busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t1_busy_fall_bound", 32'(k < 50), 32'd1);
      check("t1_pkt_held", 32'(pkt_active), 32'd1);
      @(negedge clk);
      check("t1_pkt_released", 32'(pkt_active), 32'd0);

      // Packet atomicity: req1 arrives one cycle later and must wait for req0's last byte.
      do_reset();
      add_item(0, 8'h11, 1'b0);
      add_item(0, 8'h22, 1'b0);
      add_item(0, 8'h33, 1'b1);
      add_item(1, 8'h44, 1'b1);
      start_dly[1] = 1;
      run_traffic("t2", 1500);

      do_reset();
      for (int r = 0; r < 2; r++) begin
         add_item(0, 8'h01, 1'b1);
         add_item(1, 8'h02, 1'b1);
         add_item(2, 8'h03, 1'b1);
      end
      run_traffic("t3", 1500);

      do_reset();
      for (int rq = 0; rq < NR; rq++) begin
         for (int p = 0; p < 2; p++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++)
               add_item(rq, 8'($urandom), 1'(b == len - 1));
         end
      end
      run_traffic("trand", 3000);

      // Timeout path: busy never rises, so start and err repeat with period BT+1.
      do_reset();
      busy_force = 1'b1;
      b1 = 8'($urandom);
      tick();
      v[0] = 1'b1; d[0] = b1; l[0] = 1'b1;
      @(negedge clk);
      check("t4_ready", 32'(req_ready), 32'b001);
      prev = 1'b0;
      for (int c = 1; c <= 3 * (BT + 1); c++) begin
         tick();
         v[0] = 1'b0;
         @(negedge clk);
         check("t4_start", 32'(tx_start), 32'(c % (BT + 1) == 1));
         check("t4_err", 32'(tx_err), 32'(c % (BT + 1) == 0));
         if (tx_start) begin
            check("t4_data", 32'(tx_data), 32'(b1));
            check("t4_no_double", 32'(prev), 32'd0);
         end
         prev = tx_start;
      end

      // Reset during data bit 4 of 0x3C abandons byte and lock; req2 then wins immediately.
      do_reset();
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      tick();
      v[0] = 1'b1; d[0] = 8'h3C; l[0] = 1'b0;
      @(negedge clk);
      check("t5_ready", 32'(req_ready), 32'b001);
      tick();
      d[0] = b2; l[0] = 1'b1;
      @(negedge clk);
      check("t5_start", 32'(tx_start), 32'd1);
      check("t5_data", 32'(tx_data), 32'h3C);
      repeat (55) @(posedge clk);
      #1;
      check("t5_busy_before_rst", 32'(uart_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      line_q.delete();
      v[0] = 1'b0;
      v[2] = 1'b1; d[2] = b3; l[2] = 1'b1;
      @(negedge clk);
      check("t5_state_idle", 32'(dut.state), 32'(ST_IDLE));
      check("t5_start_low", 32'(tx_start), 32'd0);
      check("t5_pkt_cleared", 32'(pkt_active), 32'd0);
      check("t5_grant_cleared", 32'(grant_id), 32'd0);
      check("t5_uart_idle", 32'(uart_busy), 32'd0);
      check("t5_ready_req2", 32'(req_ready), 32'b100);
      tick();
      v[2] = 1'b0;
      @(negedge clk);
      check("t5_start_req2", 32'(tx_start), 32'd1);
      check("t5_grant_req2", 32'(grant_id), 32'd2);
      check("t5_data_req2", 32'(tx_data), 32'(b3));
      wait_line("t5", 1, 300);
      if (line_q.size() > 0) check("t5_line", 32'(line_q[0]), 32'({1'b0, b3}));

      // Owner stalls mid-packet for 50 idle-line cycles; req1 must stay blocked.
      do_reset();
      add_item(0, 8'($urandom), 1'b0);
      add_item(0, 8'($urandom), 1'b1);
      add_item(1, 8'($urandom), 1'b1);
      pause_rq = 0;
      pause_after = 1;
      pause_left = 50;
      run_traffic("t6", 1500);
      check("t6_pause_elapsed", 32'(pause_left), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
